rab_ar_sender: RTL

Read-address sender at the output side of the RAB lookup stage. It consumes the one-cycle accept/drop decision pulses and the registered translated address from the lookup FSM. Accepted requests are issued on the master AXI AR channel. Dropped requests are answered on the slave AXI R channel with SLVERR beats. A one-cycle `sent` pulse closes the lookup FSM's WAIT state.

---
 rtl/rab_ar_sender_if.sv | 42 ++++
 rtl/rab_ar_sender.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rab_ar_sender_if.sv
// Channel interfaces for rab_ar_sender.
//   rab_ar_chan_if : AXI read-address channel. The master modport drives
//                    valid and the payload, and samples ready.
//   rab_r_chan_if  : AXI read-data channel. The slave modport drives
//                    valid, id, data, resp and last, and samples ready.
interface rab_ar_chan_if #(
  parameter int AW = 40,
  parameter int IW = 4,
  parameter int UW = 4
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [IW-1:0] id;
  logic [7:0]    len;
  logic [2:0]    size;
  logic [1:0]    burst;
  logic          lock;
  logic [3:0]    cache;
  logic [2:0]    prot;
  logic [UW-1:0] user;

  modport master (output valid, addr, id, len, size, burst, lock, cache, prot, user,
                  input  ready);
  modport slave  (input  valid, addr, id, len, size, burst, lock, cache, prot, user,
                  output ready);
endinterface

interface rab_r_chan_if #(
  parameter int DW = 64,
  parameter int IW = 4
);
  logic          valid;
  logic          ready;
  logic [IW-1:0] id;
  logic [DW-1:0] data;
  logic [1:0]    resp;
  logic          last;

  modport slave  (output valid, id, data, resp, last, input  ready);
  modport master (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rab_ar_sender.sv
// rab_ar_sender: output side of the RAB lookup stage.
// An accept pulse issues the translated read on the master AR channel.
// A drop pulse answers the original read with len+1 SLVERR beats on the
// slave R channel. Either path ends with a one-cycle `sent` pulse.
// Ports:
//   Clk_CI, Rst_RI       clock, synchronous active-high reset
//   accept, drop         one-cycle decision pulses (accept has priority)
//   out_addr_reg         translated address, valid with accept
//   cache_coherent_reg   forces AxCACHE to 4'b1111 when set
//   s_ar_*               original AR fields, held stable until `sent`
//   m_ar                 master AR channel (interface)
//   s_r                  slave R channel (interface)
//   sent                 transaction-complete pulse
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module rab_ar_sender #(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic                      accept,
  input  logic                      drop,
  input  logic [AXI_ADDR_WIDTH-1:0] out_addr_reg,
  input  logic                      cache_coherent_reg,
  input  logic [AXI_ID_WIDTH-1:0]   s_ar_id,
  input  logic [7:0]                s_ar_len,
  input  logic [2:0]                s_ar_size,
  input  logic [1:0]                s_ar_burst,
  input  logic                      s_ar_lock,
  input  logic [3:0]                s_ar_cache,
  input  logic [2:0]                s_ar_prot,
  input  logic [AXI_USER_WIDTH-1:0] s_ar_user,
  rab_ar_chan_if.master             m_ar,
  rab_r_chan_if.slave               s_r,
  output logic                      sent
);

  typedef enum logic [1:0] {IDLE, SEND_AR, ERR_R} state_e;

  state_e                    state_q, state_d;
  logic                      ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic                      ar_lock_q, ar_lock_d;
  logic [3:0]                ar_cache_q, ar_cache_d;
  logic [2:0]                ar_prot_q, ar_prot_d;
  logic [AXI_USER_WIDTH-1:0] ar_user_q, ar_user_d;
  logic                      r_valid_q, r_valid_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic                      r_last_q, r_last_d;
  logic [7:0]                r_len_q, r_len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      sent_q, sent_d;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= IDLE;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_lock_q  <= 1'b0;
      ar_cache_q <= '0;
      ar_prot_q  <= '0;
      ar_user_q  <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      r_len_q    <= '0;
      cnt_q      <= '0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_lock_q  <= ar_lock_d;
      ar_cache_q <= ar_cache_d;
      ar_prot_q  <= ar_prot_d;
      ar_user_q  <= ar_user_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      r_len_q    <= r_len_d;
      cnt_q      <= cnt_d;
      sent_q     <= sent_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_lock_d  = ar_lock_q;
    ar_cache_d = ar_cache_q;
    ar_prot_d  = ar_prot_q;
    ar_user_d  = ar_user_q;
    r_valid_d  = r_valid_q;
    r_id_d     = r_id_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    r_len_d    = r_len_q;
    cnt_d      = cnt_q;
    sent_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ar_valid_d = 1'b1;
          ar_addr_d  = out_addr_reg;
          ar_id_d    = s_ar_id;
          ar_len_d   = s_ar_len;
          ar_size_d  = s_ar_size;
          ar_burst_d = s_ar_burst;
          ar_lock_d  = s_ar_lock;
          // Coherent accesses go out as write-back read/write-allocate.
          ar_cache_d = cache_coherent_reg ? 4'b1111 : s_ar_cache;
          ar_prot_d  = s_ar_prot;
          ar_user_d  = s_ar_user;
          state_d    = SEND_AR;
        end else if (drop) begin
          r_valid_d = 1'b1;
          r_id_d    = s_ar_id;
          r_resp_d  = 2'b10;
          r_len_d   = s_ar_len;
          cnt_d     = '0;
          // last is registered, so a single-beat burst must flag it now.
          r_last_d  = (s_ar_len == 8'd0);
          state_d   = ERR_R;
        end
      end
      SEND_AR: begin
        if (m_ar.ready) begin
          ar_valid_d = 1'b0;
          sent_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      ERR_R: begin
        if (s_r.ready) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
            sent_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            // Counter only advances below len, so len=255 never wraps.
            cnt_d    = cnt_q + 8'd1;
            r_last_d = ((cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_ar.valid = ar_valid_q;
  assign m_ar.addr  = ar_addr_q;
  assign m_ar.id    = ar_id_q;
  assign m_ar.len   = ar_len_q;
  assign m_ar.size  = ar_size_q;
  assign m_ar.burst = ar_burst_q;
  assign m_ar.lock  = ar_lock_q;
  assign m_ar.cache = ar_cache_q;
  assign m_ar.prot  = ar_prot_q;
  assign m_ar.user  = ar_user_q;

  assign s_r.valid = r_valid_q;
  assign s_r.id    = r_id_q;
  assign s_r.data  = '0;
  assign s_r.resp  = r_resp_q;
  assign s_r.last  = r_last_q;

  assign sent = sent_q;

endmodule
